// File: rtl/core_shifter_arb_if.sv
// rtl/core_shifter_arb_if.sv - request/response and shifter-operand bundle for core_shifter_arb
//
// Purpose: carries both requester channels and the shared shifter connection.
//   The slave modport is the arbiter's view; the master modport is the view
//   seen by the requesters and the external combinational shifter.
//
// Signal summary (i = 0,1):
//   req_valid_i / req_ready_i        request handshake
//   req_op_i[1:0]                    00 LSL, 01 LSR, 10 ASR, 11 ROR
//   req_put_carry_i, req_base_i[W], req_shift_i[8], req_c_in_i   request fields
//   rsp_valid_i / rsp_ready_i        response handshake
//   rsp_q_i[W], rsp_c_i              response payload
//   sh_ror, sh_shr, sh_sign_extend, sh_put_carry   shifter control
//   sh_base[W], sh_shift[8], sh_c_in                shifter operands
//   sh_q[W], sh_c                                   shifter result
interface core_shifter_arb_if #(
    parameter int W = 32
);
    logic         req_valid_0;
    logic         req_ready_0;
    logic [1:0]   req_op_0;
    logic         req_put_carry_0;
    logic [W-1:0] req_base_0;
    logic [7:0]   req_shift_0;
    logic         req_c_in_0;
    logic         rsp_valid_0;
    logic         rsp_ready_0;
    logic [W-1:0] rsp_q_0;
    logic         rsp_c_0;

    logic         req_valid_1;
    logic         req_ready_1;
    logic [1:0]   req_op_1;
    logic         req_put_carry_1;
    logic [W-1:0] req_base_1;
    logic [7:0]   req_shift_1;
    logic         req_c_in_1;
    logic         rsp_valid_1;
    logic         rsp_ready_1;
    logic [W-1:0] rsp_q_1;
    logic         rsp_c_1;

    logic         sh_ror;
    logic         sh_shr;
    logic         sh_sign_extend;
    logic         sh_put_carry;
    logic [W-1:0] sh_base;
    logic [7:0]   sh_shift;
    logic         sh_c_in;
    logic [W-1:0] sh_q;
    logic         sh_c;

    modport slave (
        input  req_valid_0, req_op_0, req_put_carry_0, req_base_0, req_shift_0, req_c_in_0,
        output req_ready_0,
        output rsp_valid_0, rsp_q_0, rsp_c_0,
        input  rsp_ready_0,
        input  req_valid_1, req_op_1, req_put_carry_1, req_base_1, req_shift_1, req_c_in_1,
        output req_ready_1,
        output rsp_valid_1, rsp_q_1, rsp_c_1,
        input  rsp_ready_1,
        output sh_ror, sh_shr, sh_sign_extend, sh_put_carry, sh_base, sh_shift, sh_c_in,
        input  sh_q, sh_c
    );

    modport master (
        output req_valid_0, req_op_0, req_put_carry_0, req_base_0, req_shift_0, req_c_in_0,
        input  req_ready_0,
        input  rsp_valid_0, rsp_q_0, rsp_c_0,
        output rsp_ready_0,
        output req_valid_1, req_op_1, req_put_carry_1, req_base_1, req_shift_1, req_c_in_1,
        input  req_ready_1,
        input  rsp_valid_1, rsp_q_1, rsp_c_1,
        output rsp_ready_1,
        input  sh_ror, sh_shr, sh_sign_extend, sh_put_carry, sh_base, sh_shift, sh_c_in,
        output sh_q, sh_c
    );
endinterface

// File: rtl/core_shifter_arb.sv
// rtl/core_shifter_arb.sv - two-requester arbiter time-sharing one combinational shifter
//
// Purpose: each cycle at most one of two requesters is granted the external
//   shifter. The granted request is decoded onto the sh_* outputs, the
//   shifter result is captured into that requester's one-entry response slot
//   at the next rising edge, and a 1-bit round-robin pointer alternates
//   preference after every grant.
//
// Ports:
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    core_shifter_arb_if.slave: both request/response channels plus
//          the shifter control/operand outputs and result inputs
module core_shifter_arb #(
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    core_shifter_arb_if.slave        bus
);
    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic         ptr;
    logic         elig_0, elig_1;
    logic         gnt_0, gnt_1;

    logic [1:0]   g_op;
    logic         g_put_carry;
    logic [W-1:0] g_base;
    logic [7:0]   g_shift;
    logic         g_c_in;

    logic         rsp_valid_0_r, rsp_valid_1_r;
    logic [W-1:0] rsp_q_0_r, rsp_q_1_r;
    logic         rsp_c_0_r, rsp_c_1_r;

    // A requester may only be granted if its response slot is empty or is
    // being drained this cycle. Gating with rst_n keeps ready and all sh_*
    // outputs low while reset is held, even if requests are presented.
    assign elig_0 = rst_n && bus.req_valid_0 && (!rsp_valid_0_r || bus.rsp_ready_0);
    assign elig_1 = rst_n && bus.req_valid_1 && (!rsp_valid_1_r || bus.rsp_ready_1);

    // ptr == 0 prefers requester 0; the other one wins only if the preferred
    // requester is not eligible.
    assign gnt_0 = elig_0 && (!ptr || !elig_1);
    assign gnt_1 = elig_1 && ( ptr || !elig_0);

    assign bus.req_ready_0 = gnt_0;
    assign bus.req_ready_1 = gnt_1;

    // Granted-request mux; with no grant everything is zero, which also
    // decodes as LSL so all control outputs fall to 0.
    always_comb begin
        g_op        = OP_LSL;
        g_put_carry = 1'b0;
        g_base      = '0;
        g_shift     = '0;
        g_c_in      = 1'b0;
        if (gnt_0) begin
            g_op        = bus.req_op_0;
            g_put_carry = bus.req_put_carry_0;
            g_base      = bus.req_base_0;
            g_shift     = bus.req_shift_0;
            g_c_in      = bus.req_c_in_0;
        end else if (gnt_1) begin
            g_op        = bus.req_op_1;
            g_put_carry = bus.req_put_carry_1;
            g_base      = bus.req_base_1;
            g_shift     = bus.req_shift_1;
            g_c_in      = bus.req_c_in_1;
        end
    end

    // Op decode. Carry insertion only has meaning for right shifts, so
    // put_carry is suppressed for LSL and ROR.
    always_comb begin
        bus.sh_ror         = 1'b0;
        bus.sh_shr         = 1'b0;
        bus.sh_sign_extend = 1'b0;
        bus.sh_put_carry   = 1'b0;
        case (g_op)
            OP_LSR: begin
                bus.sh_shr       = 1'b1;
                bus.sh_put_carry = g_put_carry;
            end
            OP_ASR: begin
                bus.sh_shr         = 1'b1;
                bus.sh_sign_extend = 1'b1;
                bus.sh_put_carry   = g_put_carry;
            end
            OP_ROR: begin
                bus.sh_ror = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Shift amounts go through untouched; out-of-range behaviour is the
    // shifter's business.
    assign bus.sh_base  = g_base;
    assign bus.sh_shift = g_shift;
    assign bus.sh_c_in  = g_c_in;

    // Round-robin pointer: flip away from whoever was just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt_0) begin
            ptr <= 1'b1;
        end else if (gnt_1) begin
            ptr <= 1'b0;
        end
    end

    // Response slot 0. A grant in the draining cycle refills the slot, so
    // valid stays high and the payload is replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_0_r <= 1'b0;
            rsp_q_0_r     <= '0;
            rsp_c_0_r     <= 1'b0;
        end else if (gnt_0) begin
            rsp_valid_0_r <= 1'b1;
            rsp_q_0_r     <= bus.sh_q;
            rsp_c_0_r     <= bus.sh_c;
        end else if (bus.rsp_ready_0) begin
            rsp_valid_0_r <= 1'b0;
        end
    end

    // Response slot 1, same behaviour as slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_1_r <= 1'b0;
            rsp_q_1_r     <= '0;
            rsp_c_1_r     <= 1'b0;
        end else if (gnt_1) begin
            rsp_valid_1_r <= 1'b1;
            rsp_q_1_r     <= bus.sh_q;
            rsp_c_1_r     <= bus.sh_c;
        end else if (bus.rsp_ready_1) begin
            rsp_valid_1_r <= 1'b0;
        end
    end

    assign bus.rsp_valid_0 = rsp_valid_0_r;
    assign bus.rsp_q_0     = rsp_q_0_r;
    assign bus.rsp_c_0     = rsp_c_0_r;
    assign bus.rsp_valid_1 = rsp_valid_1_r;
    assign bus.rsp_q_1     = rsp_q_1_r;
    assign bus.rsp_c_1     = rsp_c_1_r;
endmodule

// File: tb/tb_core_shifter_arb.sv
// tb/tb_core_shifter_arb.sv - self-checking bench for core_shifter_arb
module tb_core_shifter_arb;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    core_shifter_arb_if #(.W(W)) ifc();

    core_shifter_arb #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Behavioural shifter: returns {carry, result}. Carry is the last bit
    // shifted or rotated out; shift 0 passes base and c_in through.
    function automatic logic [W:0] ref_shift(input logic [1:0] op, input logic [W-1:0] base,
                                             input logic [7:0] shift, input logic c_in);
        int s;
        int r;
        logic [W-1:0] q;
        logic c;
        s = int'(shift);
        q = base;
        c = c_in;
        if (s != 0) begin
            case (op)
                2'b00: begin
                    q = (s >= W) ? '0 : (base << s);
                    c = (s > W) ? 1'b0 : base[W-s];
                end
                2'b01: begin
                    q = (s >= W) ? '0 : (base >> s);
                    c = (s > W) ? 1'b0 : base[s-1];
                end
                2'b10: begin
                    q = (s >= W) ? {W{base[W-1]}} : W'($signed(base) >>> s);
                    c = (s > W) ? base[W-1] : base[s-1];
                end
                default: begin
                    r = s % W;
                    q = (r == 0) ? base : ((base >> r) | (base << (W - r)));
                    c = q[W-1];
                end
            endcase
        end
        return {c, q};
    endfunction

    // External combinational shifter stub driven from the arbiter's outputs.
    logic [1:0] stub_op;
    always_comb begin
        stub_op = ifc.sh_ror ? 2'b11 : (ifc.sh_shr ? (ifc.sh_sign_extend ? 2'b10 : 2'b01) : 2'b00);
        {ifc.sh_c, ifc.sh_q} = ref_shift(stub_op, ifc.sh_base, ifc.sh_shift, ifc.sh_c_in);
    end

    // Requester stimulus state
    logic         r_v[2];
    logic [1:0]   r_op[2];
    logic         r_pc[2];
    logic [W-1:0] r_base[2];
    logic [7:0]   r_sh[2];
    logic         r_cin[2];
    logic         r_rr[2];

    // Reference model: preference pointer and one response slot per requester
    logic         m_ptr;
    logic         m_v[2];
    logic [W-1:0] m_q[2];
    logic         m_c[2];
    logic         g[2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ifc.req_valid_0 = r_v[0]; ifc.req_op_0 = r_op[0]; ifc.req_put_carry_0 = r_pc[0];
        ifc.req_base_0 = r_base[0]; ifc.req_shift_0 = r_sh[0]; ifc.req_c_in_0 = r_cin[0];
        ifc.rsp_ready_0 = r_rr[0];
        ifc.req_valid_1 = r_v[1]; ifc.req_op_1 = r_op[1]; ifc.req_put_carry_1 = r_pc[1];
        ifc.req_base_1 = r_base[1]; ifc.req_shift_1 = r_sh[1]; ifc.req_c_in_1 = r_cin[1];
        ifc.rsp_ready_1 = r_rr[1];
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic pc,
                           input logic [W-1:0] base, input logic [7:0] sh, input logic cin,
                           input logic rr);
        r_v[i] = v; r_op[i] = op; r_pc[i] = pc; r_base[i] = base;
        r_sh[i] = sh; r_cin[i] = cin; r_rr[i] = rr;
    endtask

    task automatic check_rsp();
        check("rsp_valid0", ifc.rsp_valid_0, m_v[0]);
        check("rsp_valid1", ifc.rsp_valid_1, m_v[1]);
        if (m_v[0]) begin
            check("rsp_q0", ifc.rsp_q_0, m_q[0]);
            check("rsp_c0", ifc.rsp_c_0, m_c[0]);
        end
        if (m_v[1]) begin
            check("rsp_q1", ifc.rsp_q_1, m_q[1]);
            check("rsp_c1", ifc.rsp_c_1, m_c[1]);
        end
    endtask

    // One clock: called at a falling edge with stimulus already in r_*.
    task automatic do_cycle();
        logic e[2];
        int w;
        logic [1:0] op;
        logic x_ror, x_shr, x_sx, x_pc, x_cin;
        logic [W-1:0] x_base;
        logic [7:0] x_sh;
        drive();
        #1;
        for (int i = 0; i < 2; i++) e[i] = r_v[i] && (!m_v[i] || r_rr[i]);
        g[0] = e[0] && (!m_ptr || !e[1]);
        g[1] = e[1] && (m_ptr || !e[0]);
        check("req_ready0", ifc.req_ready_0, g[0]);
        check("req_ready1", ifc.req_ready_1, g[1]);
        w = g[0] ? 0 : (g[1] ? 1 : -1);
        {x_ror, x_shr, x_sx, x_pc, x_cin, x_base, x_sh} = '0;
        if (w >= 0) begin
            op = r_op[w];
            x_ror = (op == 2'b11);
            x_shr = (op == 2'b01) || (op == 2'b10);
            x_sx  = (op == 2'b10);
            x_pc  = x_shr && r_pc[w];
            x_base = r_base[w];
            x_sh   = r_sh[w];
            x_cin  = r_cin[w];
        end
        check("sh_ror", ifc.sh_ror, x_ror);
        check("sh_shr", ifc.sh_shr, x_shr);
        check("sh_sign_extend", ifc.sh_sign_extend, x_sx);
        check("sh_put_carry", ifc.sh_put_carry, x_pc);
        check("sh_base", ifc.sh_base, x_base);
        check("sh_shift", ifc.sh_shift, x_sh);
        check("sh_c_in", ifc.sh_c_in, x_cin);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                {m_c[i], m_q[i]} = ref_shift(r_op[i], r_base[i], r_sh[i], r_cin[i]);
                m_v[i] = 1'b1;
            end else if (r_rr[i]) begin
                m_v[i] = 1'b0;
            end
        end
        if (g[0]) m_ptr = 1'b1;
        else if (g[1]) m_ptr = 1'b0;
        @(negedge clk);
        check_rsp();
    endtask

    // Asserts reset immediately (asynchronously), with requests presented.
    task automatic do_reset();
        r_v[0] = 1'b1; r_v[1] = 1'b1; r_rr[0] = 1'b1; r_rr[1] = 1'b1;
        drive();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid0", ifc.rsp_valid_0, 1'b0);
        check("rst_rsp_valid1", ifc.rsp_valid_1, 1'b0);
        check("rst_rsp_q0", ifc.rsp_q_0, '0);
        check("rst_rsp_q1", ifc.rsp_q_1, '0);
        check("rst_rsp_c0", ifc.rsp_c_0, 1'b0);
        check("rst_rsp_c1", ifc.rsp_c_1, 1'b0);
        check("rst_req_ready0", ifc.req_ready_0, 1'b0);
        check("rst_req_ready1", ifc.req_ready_1, 1'b0);
        check("rst_sh_base", ifc.sh_base, '0);
        m_ptr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_q[i] = '0; m_c[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        r_v[0] = 1'b0; r_v[1] = 1'b0;
        drive();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_shift();
        case ($urandom_range(0, 4))
            0: return 8'd0;
            1: return 8'(W);
            2: return 8'(W + int'($urandom_range(1, 200)));
            default: return 8'($urandom_range(1, W - 1));
        endcase
    endfunction

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) set_req(i, 1'b0, 2'b00, 1'b0, '0, 8'd0, 1'b0, 1'b0);
        drive();
        @(negedge clk);

        // Reset with both requests valid: nothing may be granted or visible
        do_reset();
        do_cycle();

        // Single LSL on requester 0, latency 1
        set_req(0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 8'd4, 1'b0, 1'b1);
        do_cycle();
        check("lsl_q0", ifc.rsp_q_0, 32'h0000_0010);
        check("lsl_c0", ifc.rsp_c_0, 1'b0);
        r_v[0] = 1'b0;
        do_cycle();

        // Both requesters continuously valid: alternation starting at 0
        do_reset();
        set_req(0, 1'b1, 2'b01, 1'b1, 32'hA5A5_0F0F, 8'd3, 1'b1, 1'b1);
        set_req(1, 1'b1, 2'b11, 1'b0, 32'h1234_5678, 8'd8, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            do_cycle();
            check("alt_valid0", ifc.rsp_valid_0, (k % 2) == 0);
            check("alt_valid1", ifc.rsp_valid_1, (k % 2) == 1);
        end
        r_v[0] = 1'b0; r_v[1] = 1'b0;
        do_cycle();

        // ASR with sign extension
        set_req(0, 1'b1, 2'b10, 1'b0, 32'h8000_0000, 8'd4, 1'b0, 1'b1);
        do_cycle();
        check("asr_q0", ifc.rsp_q_0, 32'hF800_0000);
        r_v[0] = 1'b0;
        do_cycle();

        // Requester 0 blocked by an undrained response; requester 1 proceeds
        set_req(0, 1'b1, 2'b00, 1'b0, 32'h0000_0003, 8'd1, 1'b0, 1'b0);
        do_cycle();
        r_v[0] = 1'b0;
        set_req(1, 1'b1, 2'b01, 1'b0, 32'h0000_00F0, 8'd4, 1'b0, 1'b1);
        do_cycle();
        set_req(0, 1'b1, 2'b11, 1'b0, 32'hDEAD_BEEF, 8'd12, 1'b1, 1'b0);
        set_req(1, 1'b1, 2'b00, 1'b1, 32'h0F0F_0F0F, 8'd0, 1'b1, 1'b1);
        do_cycle();
        check("blocked_ready0_hold_q0", ifc.rsp_q_0, 32'h0000_0006);
        do_cycle();
        check("blocked_q0_still", ifc.rsp_q_0, 32'h0000_0006);
        r_rr[0] = 1'b1;
        r_v[1] = 1'b0;
        do_cycle();
        r_v[0] = 1'b0;
        do_cycle();

        // ROR with put_carry suppressed
        set_req(1, 1'b1, 2'b11, 1'b1, 32'h0000_0001, 8'd1, 1'b0, 1'b1);
        do_cycle();
        check("ror_q1", ifc.rsp_q_1, 32'h8000_0000);
        check("ror_c1", ifc.rsp_c_1, 1'b1);

        // Reset between edges discards the fresh response at once
        do_reset();
        check("rst_mid_valid1", ifc.rsp_valid_1, 1'b0);
        set_req(0, 1'b1, 2'b01, 1'b0, 32'h0000_0100, 8'd8, 1'b0, 1'b1);
        set_req(1, 1'b1, 2'b01, 1'b0, 32'h0000_0200, 8'd8, 1'b0, 1'b1);
        do_cycle();
        check("post_rst_grant0", ifc.rsp_valid_0, 1'b1);
        check("post_rst_no_grant1", ifc.rsp_valid_1, 1'b0);

        // Randomized traffic; held requests keep their fields until granted
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!r_v[i] || g[i]) begin
                    r_v[i]    = ($urandom_range(0, 3) != 0);
                    r_op[i]   = 2'($urandom_range(0, 3));
                    r_pc[i]   = 1'($urandom_range(0, 1));
                    r_base[i] = ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : W'($urandom);
                    r_sh[i]   = rand_shift();
                    r_cin[i]  = 1'($urandom_range(0, 1));
                end
                r_rr[i] = ($urandom_range(0, 2) != 0);
            end
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
